// File: rtl/elevator_controller.sv
// Single-car SCAN elevator controller with pending-request set, timed door and cabin climate.
// State table: IDLE | parked, door shut; MOVING_UP | motor_up on; MOVING_DOWN | motor_down on; DOOR_OPEN | door timer running
module elevator_controller #(
  parameter int        NUM_FLOORS  = 16,
  parameter int        DOOR_CYCLES = 4,
  parameter int signed TEMP_LOW    = 18,
  parameter int signed TEMP_HIGH   = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               off_btn,
  input  logic [31:0]        position,
  input  logic [31:0]        floor_press_event,
  input  logic [31:0]        cabin_press_event,
  input  logic signed [31:0] temp,
  output logic               door,
  output logic               cooler,
  output logic               heater,
  output logic               motor_up,
  output logic               motor_down
);

  typedef enum logic [1:0] {IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPEN} state_t;

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DOOR_CYCLES - 1);

  state_t                r_state;
  logic                  r_last_dir;
  logic [CNT_W-1:0]      r_cnt;
  logic [NUM_FLOORS:1]   r_req;
  logic                  r_door, r_cooler, r_heater, r_motor_up, r_motor_down;

  state_t                w_next;
  logic                  w_next_dir;
  logic [CNT_W-1:0]      w_next_cnt;
  logic [NUM_FLOORS:1]   w_set, w_clr, w_here_vec;
  logic                  w_here, w_above, w_below, w_pos_ok, w_repress;

  // Request decode relative to the current floor; presses for the open-door floor are not latched.
  always_comb begin
    w_here     = 1'b0;
    w_above    = 1'b0;
    w_below    = 1'b0;
    w_set      = '0;
    w_here_vec = '0;
    w_pos_ok   = (position >= 32'd1) && (position <= 32'(NUM_FLOORS));
    w_repress  = (r_state == DOOR_OPEN) && w_pos_ok &&
                 ((floor_press_event == position) || (cabin_press_event == position));
    for (int i = 1; i <= NUM_FLOORS; i++) begin
      if (position == 32'(i)) w_here_vec[i] = 1'b1;
      if (r_req[i] && (position == 32'(i))) w_here = 1'b1;
      if (r_req[i] && (32'(i) > position)) w_above = 1'b1;
      if (r_req[i] && (32'(i) < position)) w_below = 1'b1;
      if (((floor_press_event == 32'(i)) || (cabin_press_event == 32'(i))) &&
          !((r_state == DOOR_OPEN) && (position == 32'(i))))
        w_set[i] = 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_next_dir = r_last_dir;
    w_next_cnt = r_cnt;
    w_clr      = '0;
    case (r_state)
      IDLE: begin
        if (w_here) begin
          w_next     = DOOR_OPEN;
          w_next_cnt = CNT_LOAD;
          w_clr      = w_here_vec;
        end else if (r_last_dir ? w_above : w_below) begin
          w_next = r_last_dir ? MOVING_UP : MOVING_DOWN;
        end else if (r_last_dir ? w_below : w_above) begin
          w_next     = r_last_dir ? MOVING_DOWN : MOVING_UP;
          w_next_dir = ~r_last_dir;
        end
      end
      MOVING_UP: begin
        if (w_here) begin
          w_next     = DOOR_OPEN;
          w_next_cnt = CNT_LOAD;
          w_clr      = w_here_vec;
        end else if (!w_above || (position == 32'(NUM_FLOORS))) begin
          w_next = IDLE;
        end
      end
      MOVING_DOWN: begin
        if (w_here) begin
          w_next     = DOOR_OPEN;
          w_next_cnt = CNT_LOAD;
          w_clr      = w_here_vec;
        end else if (!w_below || (position == 32'd1)) begin
          w_next = IDLE;
        end
      end
      DOOR_OPEN: begin
        if (w_repress)           w_next_cnt = CNT_LOAD;
        else if (r_cnt == '0)    w_next     = IDLE;
        else                     w_next_cnt = r_cnt - CNT_W'(1);
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_dir   <= 1'b1;
      r_cnt        <= '0;
      r_req        <= '0;
      r_door       <= 1'b0;
      r_cooler     <= 1'b0;
      r_heater     <= 1'b0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
    end else if (off_btn) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_door       <= 1'b1;
      r_cooler     <= 1'b0;
      r_heater     <= 1'b0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_last_dir   <= w_next_dir;
      r_cnt        <= w_next_cnt;
      // A press wins over a clear of the same bit
      r_req        <= (r_req & ~w_clr) | w_set;
      r_door       <= (w_next == DOOR_OPEN);
      r_motor_up   <= (w_next == MOVING_UP);
      r_motor_down <= (w_next == MOVING_DOWN);
      r_heater     <= (temp < TEMP_LOW);
      r_cooler     <= (temp > TEMP_HIGH);
    end
  end

  assign door       = r_door;
  assign cooler     = r_cooler;
  assign heater     = r_heater;
  assign motor_up   = r_motor_up;
  assign motor_down = r_motor_down;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: expected {door,cooler,heater,motor_up,motor_down} queued per step.
module tb_elevator_controller;

  logic               clock = 1'b0;
  logic               reset, off_btn;
  logic [31:0]        position, floor_press_event, cabin_press_event;
  logic signed [31:0] temp;
  logic               door, cooler, heater, motor_up, motor_down;
  logic [4:0]         w_outs;
  logic [4:0]         sb_q[$];
  int                 n_checks = 0;
  int                 n_pass   = 0;

  elevator_controller dut (
    .clock             (clock),
    .reset             (reset),
    .off_btn           (off_btn),
    .position          (position),
    .floor_press_event (floor_press_event),
    .cabin_press_event (cabin_press_event),
    .temp              (temp),
    .door              (door),
    .cooler            (cooler),
    .heater            (heater),
    .motor_up          (motor_up),
    .motor_down        (motor_down)
  );

  always #5 clock = ~clock;
  assign w_outs = {door, cooler, heater, motor_up, motor_down};

  task automatic drive(input logic rst, input logic off, input logic [31:0] pos,
                       input logic [31:0] fp, input logic [31:0] cp, input int tmp);
    reset = rst; off_btn = off; position = pos;
    floor_press_event = fp; cabin_press_event = cp; temp = tmp;
  endtask

  task automatic test_reset();
    logic [4:0] want;
    for (int s = 0; s < 8; s++) begin
      if (s < 5) drive(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 20),
                       $urandom_range(0, 20), int'($urandom_range(0, 80)) - 40);
      else       drive(1'b0, 1'b0, 32'd1, 32'd0, 32'd0, 20);
      sb_q.push_back(5'b00000);
      @(posedge clock); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (w_outs !== want) $display("FAIL reset step %0d outs=%b expected=%b", s, w_outs, want);
      else n_pass++;
    end
  endtask

  task automatic test_up_trip();
    logic [31:0] pos_t[7] = '{1, 1, 2, 2, 2, 2, 2};
    logic [31:0] cab_t[7] = '{2, 0, 0, 0, 0, 0, 0};
    logic [4:0]  exp_t[7] = '{5'b00000, 5'b00010, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b00000};
    logic [4:0]  want;
    for (int s = 0; s < 7; s++) begin
      drive(1'b0, 1'b0, pos_t[s], 32'd0, cab_t[s], 20);
      sb_q.push_back(exp_t[s]);
      @(posedge clock); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (w_outs !== want) $display("FAIL up_trip step %0d outs=%b expected=%b", s, w_outs, want);
      else n_pass++;
    end
  endtask

  task automatic test_same_floor();
    logic [31:0] fl_t[9]  = '{3, 0, 0, 3, 0, 0, 0, 0, 0};
    logic [4:0]  exp_t[9] = '{5'b00000, 5'b10000, 5'b10000, 5'b10000, 5'b10000,
                              5'b10000, 5'b10000, 5'b00000, 5'b00000};
    logic [4:0]  want;
    for (int s = 0; s < 9; s++) begin
      drive(1'b0, 1'b0, 32'd3, fl_t[s], 32'd0, 20);
      sb_q.push_back(exp_t[s]);
      @(posedge clock); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (w_outs !== want) $display("FAIL same_floor step %0d outs=%b expected=%b", s, w_outs, want);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    logic [31:0] pos_t[17] = '{5, 5, 5, 6, 7, 7, 7, 7, 7, 7, 4, 2, 2, 2, 2, 2, 2};
    logic [31:0] fl_t[17]  = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] cab_t[17] = '{17, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [4:0]  exp_t[17] = '{5'b00000, 5'b00000, 5'b00010, 5'b00010, 5'b10000, 5'b10000,
                               5'b10000, 5'b10000, 5'b00000, 5'b00001, 5'b00001, 5'b10000,
                               5'b10000, 5'b10000, 5'b10000, 5'b00000, 5'b00000};
    logic [4:0]  want;
    for (int s = 0; s < 17; s++) begin
      drive(1'b0, 1'b0, pos_t[s], fl_t[s], cab_t[s], 20);
      sb_q.push_back(exp_t[s]);
      @(posedge clock); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (w_outs !== want) $display("FAIL scan step %0d outs=%b expected=%b", s, w_outs, want);
      else n_pass++;
    end
  endtask

  task automatic test_off_btn();
    logic        off_t[8]  = '{0, 0, 0, 1, 1, 0, 0, 0};
    logic [31:0] pos_t[8]  = '{2, 2, 3, 3, 3, 3, 3, 3};
    logic [31:0] cab_t[8]  = '{9, 0, 0, 0, 4, 0, 0, 0};
    int          tmp_t[8]  = '{20, 20, 30, 30, 30, 30, 20, 20};
    logic [4:0]  exp_t[8]  = '{5'b00000, 5'b00010, 5'b01010, 5'b10000,
                               5'b10000, 5'b01000, 5'b00000, 5'b00000};
    logic [4:0]  want;
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, off_t[s], pos_t[s], 32'd0, cab_t[s], tmp_t[s]);
      sb_q.push_back(exp_t[s]);
      @(posedge clock); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (w_outs !== want) $display("FAIL off_btn step %0d outs=%b expected=%b", s, w_outs, want);
      else n_pass++;
    end
  endtask

  task automatic test_climate();
    int         tmp_t[7] = '{-5, 18, 30, 25, 17, 26, 20};
    logic [4:0] exp_t[7] = '{5'b00100, 5'b00000, 5'b01000, 5'b00000, 5'b00100, 5'b01000, 5'b00000};
    logic [4:0] want;
    for (int s = 0; s < 7; s++) begin
      drive(1'b0, 1'b0, 32'd3, 32'd0, 32'd0, tmp_t[s]);
      sb_q.push_back(exp_t[s]);
      @(posedge clock); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (w_outs !== want) $display("FAIL climate temp=%0d outs=%b expected=%b", tmp_t[s], w_outs, want);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back_reset();
    logic        rst_t[5]  = '{0, 0, 1, 0, 0};
    logic [31:0] cab_t[5]  = '{5, 0, 0, 0, 0};
    logic [4:0]  exp_t[5]  = '{5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000};
    logic [4:0]  want;
    for (int s = 0; s < 5; s++) begin
      drive(rst_t[s], 1'b0, 32'd1, 32'd0, cab_t[s], 20);
      sb_q.push_back(exp_t[s]);
      @(posedge clock); #1;
      want = sb_q.pop_front();
      n_checks++;
      if (w_outs !== want) $display("FAIL midtravel_reset step %0d outs=%b expected=%b", s, w_outs, want);
      else n_pass++;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'd1, 32'd0, 32'd0, 20);
    @(posedge clock); #1;
    test_reset();
    test_up_trip();
    test_same_floor();
    test_scan();
    test_off_btn();
    test_climate();
    test_back_to_back_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
# elevator_controller

Single-car elevator controller with a built-in cabin climate regulator. It accepts hall (floor) and cabin call events, holds them in a pending-request set, and drives motor and door outputs with a SCAN (continue-in-direction) policy. Floor position comes from an external sensor as a floor number. This block sits between the building I/O (buttons, floor sensor, thermometer) and the car actuators.

## Interface
- `NUM_FLOORS`, default 16: floors are numbered 1..NUM_FLOORS.
- `DOOR_CYCLES`, default 4: number of cycles the door stays open per stop.
- `TEMP_LOW`, default 18: the heater turns on when `temp` is below this value (signed).
- `TEMP_HIGH`, default 25: the cooler turns on when `temp` is above this value (signed).
- `clock` input 1: the single clock; every register updates on its rising edge.
- `reset` input 1: synchronous and active-high.
- `off_btn` input 1: service-off level; while high, the car is out of service.
- `position` input 32: current floor number, unsigned, from the sensor.
- `floor_press_event` input 32: hall call floor number; 0 means no event this cycle.
- `cabin_press_event` input 32: cabin call floor number; 0 means no event this cycle.
- `temp` input 32: signed cabin temperature.
- `door` output 1: 1 means the door is open.
- `cooler` output 1: cooler on.
- `heater` output 1: heater on.
- `motor_up` output 1: drive the car up.
- `motor_down` output 1: drive the car down.

## Operation
- **Request register**: `req[1..NUM_FLOORS]`.
  - On each edge, a press value v with 1 ≤ v ≤ NUM_FLOORS sets `req[v]`.
  - The hall and cabin events are both accepted in the same cycle.
  - Values of 0 or above NUM_FLOORS are ignored.
  - A press that coincides with the clearing of the same bit wins: the bit stays set, unless the press is for the floor where the door is currently open (see DOOR_OPEN).
- **FSM states**: IDLE, MOVING_UP, MOVING_DOWN, DOOR_OPEN. The block also keeps a 1-bit register `last_dir`, which resets to up.
- **IDLE**:
  - If `req[position]` is set, clear it and go to DOOR_OPEN.
  - Otherwise, if requests exist in `last_dir`'s direction, move that way.
  - Otherwise, if requests exist in the opposite direction, move that way and flip `last_dir`.
  - Otherwise, stay in IDLE.
- **MOVING_UP / MOVING_DOWN**:
  - `motor_up` (respectively `motor_down`) is 1 in this state.
  - Each cycle, if `req[position]` is set, clear it and go to DOOR_OPEN. The motor drops in the same edge.
  - If there is no request beyond `position` in the travel direction, or `position` is at the end floor (NUM_FLOORS going up, 1 going down), go to IDLE.
- **DOOR_OPEN**:
  - `door` = 1 and a counter loads DOOR_CYCLES−1.
  - The counter decrements each cycle. At 0 the state goes to IDLE.
  - A press for the current floor while the door is open reloads the counter and does not set `req`.
- **Out-of-range position**: if `position` is 0 or above NUM_FLOORS, the FSM treats it as no request at the current floor and never starts motion toward it.
- **Motor interlock**: `motor_up` and `motor_down` are never 1 together. Neither motor is ever 1 while `door` = 1.
- **off_btn high**:
  - Takes priority over the FSM.
  - Clears all requests and ignores new presses.
  - Forces the FSM to IDLE with both motors at 0 and `door` = 1 (car parked open).
  - Forces `cooler` = `heater` = 0.
  - When `off_btn` returns low, the car resumes from IDLE with `door` = 0.
- **Climate** (while not off):
  - `heater` = (temp < TEMP_LOW), `cooler` = (temp > TEMP_HIGH).
  - Comparisons are signed 32-bit and there is no hysteresis.
  - The two are mutually exclusive by construction, given TEMP_LOW ≤ TEMP_HIGH.

## Timing
- All outputs are registered.
- On `reset`, at the next edge: all outputs 0, `req` cleared, state IDLE, `last_dir` up, door counter 0. Reset has priority over `off_btn`.
- A reset asserted mid-travel or mid-door stops the motors and closes the door at that edge.
- Press sampled at edge k: `req` is set at edge k. The FSM acts on it at edge k+1, so a motor or the door output changes after edge k+1.
- Arrival: when `position` equals a requested floor at edge k, the motor is 0 and `door` is 1 after edge k.
- The door stays open exactly DOOR_CYCLES cycles, absent re-presses.
- Climate outputs follow `temp` with 1-cycle latency.

## Test plan
- **Reset**: hold `reset` high for 5 cycles with random inputs → all outputs 0. Release with `position`=1 and no presses → all outputs stay 0.
- **Up trip**: `position`=1, `cabin_press_event`=2 for 1 cycle, then 0 → `motor_up`=1 two edges later. Set `position`=2 → next edge: `motor_up`=0, `door`=1 for 4 cycles, then `door`=0 and IDLE.
- **Same-floor call**: `position`=3, `floor_press_event`=3 → `door`=1 two edges later, no motor. Re-press 3 while the door is open → the door stays open 4 more cycles.
- **SCAN order**: at floor 5 heading up, requests 7 and 2 → the car stops at 7 first, then reverses (`motor_down`) to 2. Press events 0 and 17 are ignored.
- **off_btn**: while moving up, raise `off_btn` → next edge: motors 0, `door`=1, `cooler`/`heater` 0, requests lost. Lower it → `door`=0, IDLE.
- **Climate**: `temp`=−5 → `heater`=1. `temp`=18 → both 0. `temp`=30 → `cooler`=1, each after 1 edge.
